mul_div_iter: RTL and testbench



---
 rtl/mul_div_iter.sv | 141 ++++++++++++++
 tb/tb_mul_div_iter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mul_div_iter.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide on one
// shared 2*WIDTH accumulator, with valid/ready handshakes and a synchronous flush.
module mul_div_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_src1,
    input  logic [WIDTH-1:0] in_src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH);

    state_t             state_q;
    logic [2:0]         op_q;
    logic               sign1_q;
    logic               sign2_q;
    logic               div_zero_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               in_signed;
    logic               in_div;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic               op_is_div;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     partial;
    logic [WIDTH+1:0]   trial;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   result;

    assign in_ready = (state_q == StIdle);
    assign busy     = (state_q != StIdle);

    always_comb begin
        in_signed = (in_op == 3'd0) || (in_op == 3'd1) || (in_op == 3'd3) || (in_op == 3'd4);
        in_div    = (in_op >= 3'd3) && (in_op <= 3'd6);
        mag1      = (in_signed && in_src1[WIDTH-1]) ? -in_src1 : in_src1;
        mag2      = (in_signed && in_src2[WIDTH-1]) ? -in_src2 : in_src2;
        op_is_div = (op_q >= 3'd3) && (op_q <= 3'd6);
    end

    // Multiply: the carry out of the upper-half add shifts back in at the top.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    end

    // Divide: the shifted remainder needs WIDTH+1 bits when the divisor has its MSB set.
    always_comb begin
        partial = acc_q[2*WIDTH-1:WIDTH-1];
        trial   = {1'b0, partial} - {2'b00, mcand_q};
        if (trial[WIDTH+1]) begin
            div_next = {partial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
    end

    always_comb begin
        prod_fix = (sign1_q ^ sign2_q) ? -acc_q : acc_q;
        quot_fix = ((sign1_q ^ sign2_q) && !div_zero_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = sign1_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        case (op_q)
            3'd0:       result = prod_fix[WIDTH-1:0];
            3'd1, 3'd2: result = prod_fix[2*WIDTH-1:WIDTH];
            3'd3, 3'd5: result = quot_fix;
            3'd4, 3'd6: result = rem_fix;
            default:    result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            op_q       <= '0;
            sign1_q    <= 1'b0;
            sign2_q    <= 1'b0;
            div_zero_q <= 1'b0;
            mcand_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
        end else if (flush) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_q       <= in_op;
                        sign1_q    <= in_signed & in_src1[WIDTH-1];
                        sign2_q    <= in_signed & in_src2[WIDTH-1];
                        div_zero_q <= (in_src2 == '0);
                        mcand_q    <= in_div ? mag2 : mag1;
                        acc_q      <= {{WIDTH{1'b0}}, (in_div ? mag1 : mag2)};
                        cnt_q      <= '0;
                        state_q    <= StCalc;
                    end
                end
                StCalc: begin
                    if (cnt_q == LastCnt) begin
                        out_result <= result;
                        out_valid  <= 1'b1;
                        state_q    <= StDone;
                    end else begin
                        acc_q <= op_is_div ? div_next : mul_next;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_iter.sv
// Directed-vector bench for mul_div_iter at WIDTH=32: results, latency, backpressure,
// flush and asynchronous reset.
module tb_mul_div_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    mul_div_iter #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request, check latency and result, optionally stall the consumer.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int hold);
        int cycles;
        logic [31:0] held;
        @(negedge clk);
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_op     = op;
        in_src1   = a;
        in_src2   = b;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op    = 3'($urandom);
        in_src1  = $urandom;
        in_src2  = $urandom;
        cycles   = 0;
        while (!out_valid && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check({tag, " latency"}, 32'(cycles), 32'd33);
        check({tag, " result"}, out_result, exp);
        held = out_result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, " hold"}, {29'd0, out_valid, in_ready, (out_result == held)}, 32'b101);
        end
        if (hold != 0) begin
            @(negedge clk);
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check({tag, " consumed"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        int seen;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_src1   = '0;
        in_src2   = '0;
        out_ready = 1'b1;
        #12;
        check("reset outs", {28'd0, in_ready, out_valid, busy, (out_result != 0)}, 32'b1000);
        @(negedge clk);
        reset = 1'b0;

        run_op("mul",   3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 0);
        run_op("mulh",  3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 0);
        run_op("mulhu", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 0);
        run_op("div",   3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 0);
        run_op("mod",   3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 0);
        run_op("divu",  3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 0);
        run_op("modu",  3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 0);
        run_op("div0",  3'd3, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 0);
        run_op("divu0", 3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 0);
        run_op("mod0",  3'd4, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 0);
        run_op("modu0", 3'd6, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 0);
        run_op("ndiv0", 3'd3, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 0);
        run_op("nmod0", 3'd4, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 0);
        run_op("ovdiv", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op("ovmod", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);
        run_op("ovmh",  3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);
        run_op("ovml",  3'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op("pdivn", 3'd3, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 0);
        run_op("pmodn", 3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        run_op("mulhn", 3'd1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 0);
        run_op("mulln", 3'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1, 0);
        run_op("mhubig", 3'd2, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
        run_op("divubig", 3'd5, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0001, 0);
        run_op("modubig", 3'd6, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 0);
        run_op("rsvd",  3'd7, 32'h1234_5678, 32'h0000_0003, 32'h0000_0000, 0);
        run_op("bp",    3'd5, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 10);

        // Flush part-way through the iterations.
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 3'd0;
        in_src1  = 32'd100;
        in_src2  = 32'd200;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush idle", {30'd0, in_ready, busy}, 32'b10);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("flush no valid", 32'(seen), 32'd0);
        run_op("post flush", 3'd0, 32'd3, 32'd4, 32'd12, 0);

        // Flush coincident with a request.
        @(negedge clk);
        in_valid = 1'b1;
        flush    = 1'b1;
        in_op    = 3'd0;
        in_src1  = 32'd9;
        in_src2  = 32'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush+req", {30'd0, in_ready, busy}, 32'b10);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("flush+req no valid", 32'(seen), 32'd0);

        // Asynchronous reset mid-calculation; out_result holds 12 from earlier.
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 3'd3;
        in_src1  = 32'd50;
        in_src2  = 32'd5;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async rst", {29'd0, in_ready, out_valid, busy}, 32'b100);
        check("async rst result", out_result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op("post rst", 3'd3, 32'd50, 32'd5, 32'd10, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
